mac_accum_ctrl: RTL and testbench

MAC_ACCUM_CTRL -- requirements
Module: mac_accum_ctrl

---
 rtl/mac_accum_ctrl.sv | 139 +++++++++++++
 tb/tb_mac_accum_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mac_accum_ctrl.sv
// mac_accum_ctrl
//   Sequences a dot-product run on an external DSP slice (P = a*b + c).
//   Operand sets are issued to the DSP under op_valid/op_ready. A valid
//   pipeline matching the DSP latency marks the edges where p_in holds a
//   product. That product is added into a saturating unsigned accumulator.
//   After len products have been summed, the result is presented with
//   out_valid until downstream takes it with out_ready.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   start      one-cycle run request (honoured only in IDLE)
//   len        number of products per run, latched with an accepted start
//   op_valid   upstream offers an operand set to the DSP
//   op_ready   operand set accepted this cycle (RUN, issue count < len)
//   p_in       DSP output, unsigned
//   acc_out    accumulator value / final result
//   out_valid  result valid (state DONE)
//   out_ready  downstream consumes the result
//   busy       high in RUN or DONE
//   ovf        sticky saturation flag for the current or last run
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; acc_out/ovf hold the previous result
// RUN   | issuing operands and accumulating returning products
// DONE  | result valid, waiting for out_ready
module mac_accum_ctrl #(
  parameter int P_WIDTH     = 17,
  parameter int ACC_WIDTH   = 24,
  parameter int LEN_WIDTH   = 8,
  parameter int DSP_LATENCY = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] len,
  input  logic                 op_valid,
  output logic                 op_ready,
  input  logic [P_WIDTH-1:0]   p_in,
  output logic [ACC_WIDTH-1:0] acc_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [ACC_WIDTH-1:0] ACC_MAX = '1;

  state_t               state;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] issue_cnt;
  logic [LEN_WIDTH-1:0] recv_cnt;
  logic [DSP_LATENCY-1:0] vld_sr;
  logic [DSP_LATENCY-1:0] vld_nxt;
  logic [ACC_WIDTH-1:0] acc;
  logic                 ovf_q;

  logic                 accept;
  logic                 tap;
  logic [ACC_WIDTH:0]   sum;

  assign op_ready  = (state == RUN) && (issue_cnt < len_q);
  assign accept    = op_valid && op_ready;
  assign tap       = vld_sr[DSP_LATENCY-1];

  // One spare bit on top of the accumulator catches the carry for saturation.
  assign sum = {1'b0, acc} + {{(ACC_WIDTH + 1 - P_WIDTH){1'b0}}, p_in};

  // Shift written as a plain shift so a latency of 1 needs no special case.
  always_comb begin
    vld_nxt    = vld_sr << 1;
    vld_nxt[0] = accept;
  end

  assign acc_out   = acc;
  assign ovf       = ovf_q;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      len_q     <= '0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      vld_sr    <= '0;
      acc       <= '0;
      ovf_q     <= 1'b0;
    end else begin
      vld_sr <= vld_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            len_q     <= len;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            acc       <= '0;
            ovf_q     <= 1'b0;
            vld_sr    <= '0;
            state     <= (len == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (accept) begin
            issue_cnt <= issue_cnt + 1'b1;
          end
          // The tap is only honoured here, so stale pipeline bits never
          // disturb a result sitting in DONE or IDLE.
          if (tap) begin
            if (sum[ACC_WIDTH]) begin
              acc   <= ACC_MAX;
              ovf_q <= 1'b1;
            end else begin
              acc <= sum[ACC_WIDTH-1:0];
            end
            recv_cnt <= recv_cnt + 1'b1;
            if ((recv_cnt + 1'b1) == len_q) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_accum_ctrl.sv
// Bench for mac_accum_ctrl with a 3-stage DSP model P = a*b + c.
// Expected results are queued at start and compared when out_valid rises.
module tb_mac_accum_ctrl;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  len;
  logic        op_valid;
  logic        op_ready;
  logic [16:0] p_in;
  logic [23:0] acc_out;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        ovf;

  int unsigned a_op, b_op, c_op;
  logic [16:0] dsp_pipe [LAT];

  typedef struct {
    logic [23:0] acc;
    logic        ovf;
  } exp_t;
  exp_t sb_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;

  always #5 clk = ~clk;

  mac_accum_ctrl #(
    .P_WIDTH    (17),
    .ACC_WIDTH  (24),
    .LEN_WIDTH  (8),
    .DSP_LATENCY(LAT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .len      (len),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .p_in     (p_in),
    .acc_out  (acc_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .ovf      (ovf)
  );

  // DSP model: operands presented before edge t appear on p_in after edge t+LAT-1,
  // so the product is sampled at edge t+LAT.
  always @(posedge clk) begin
    dsp_pipe[0] <= 17'(a_op * b_op + c_op);
    for (int i = 1; i < LAT; i++) dsp_pipe[i] <= dsp_pipe[i-1];
  end
  assign p_in = dsp_pipe[LAT-1];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] l, input logic [23:0] exp_acc, input logic exp_ovf);
    exp_t e;
    e.acc = exp_acc;
    e.ovf = exp_ovf;
    sb_q.push_back(e);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
    len   = 8'hAA;
  endtask

  // Drives op_valid per pattern (all ones past plen) until n operands are taken.
  // A start pulse with len=1 is injected at start_step (negative = none).
  task automatic issue_ops(input string tag, input int n, input int unsigned av, input int unsigned bv,
                           input int unsigned cv, input logic [31:0] pat, input int plen,
                           input int start_step);
    int taken = 0;
    int step  = 0;
    a_op = av;
    b_op = bv;
    c_op = cv;
    while (taken < n && step < 1000) begin
      op_valid = (step < plen) ? pat[step] : 1'b1;
      start    = (step == start_step);
      if (step == start_step) len = 8'd1;
      if (op_valid && op_ready) taken++;
      tick();
      step++;
    end
    op_valid = 1'b0;
    start    = 1'b0;
    if (taken < n) check_val({tag, "_issue_timeout"}, taken, n);
  endtask

  task automatic wait_done(input string tag, output int cycles);
    exp_t e;
    cycles = 1;
    while (!out_valid && cycles < 1000) begin
      tick();
      cycles++;
    end
    if (!out_valid) begin
      check_val({tag, "_done_timeout"}, 0, 1);
    end else if (sb_q.size() == 0) begin
      check_val({tag, "_sb_empty"}, 0, 1);
    end else begin
      e = sb_q.pop_front();
      check_val({tag, "_acc"}, acc_out, e.acc);
      check_val({tag, "_ovf"}, ovf, e.ovf);
    end
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_val({tag, "_idle_busy"}, busy, 0);
    check_val({tag, "_idle_valid"}, out_valid, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    len       = 8'd0;
    op_valid  = 1'b0;
    out_ready = 1'b0;
    a_op      = 0;
    b_op      = 0;
    c_op      = 0;
    repeat (3) tick();
    check_val("rst_acc", acc_out, 0);
    check_val("rst_ovf", ovf, 0);
    check_val("rst_valid", out_valid, 0);
    check_val("rst_ready", op_ready, 0);
    check_val("rst_busy", busy, 0);
    reset = 1'b1;
    tick();

    // Basic run: 4 x 7 = 28, then backpressure for 5 cycles.
    do_start(8'd4, 24'd28, 1'b0);
    check_val("basic_busy", busy, 1);
    issue_ops("basic", 4, 2, 3, 1, 32'hF, 4, -1);
    wait_done("basic", cyc);
    check_val("basic_latency", cyc, 4);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("bp_valid", out_valid, 1);
      check_val("bp_acc", acc_out, 28);
    end
    release_result("basic");
    tick();
    check_val("idle_keep_acc", acc_out, 28);

    // Saturation: 255 x 131071 overflows a 24-bit accumulator.
    do_start(8'd255, 24'hFFFFFF, 1'b1);
    issue_ops("sat", 255, 1, 131070, 1, 32'h0, 0, -1);
    wait_done("sat", cyc);
    release_result("sat");
    check_val("idle_keep_ovf", ovf, 1);

    // Zero length: straight to DONE with a cleared result.
    do_start(8'd0, 24'd0, 1'b0);
    wait_done("zero", cyc);
    check_val("zero_latency", cyc, 1);
    release_result("zero");

    // Gaps with a stray start mid-run: 3 x 110 = 330.
    do_start(8'd3, 24'd330, 1'b0);
    issue_ops("gap", 3, 10, 10, 10, 32'b101001, 6, 1);
    check_val("gap_ready_low", op_ready, 0);
    check_val("gap_busy", busy, 1);
    wait_done("gap", cyc);
    release_result("gap");

    // Reset mid-run after 2 of 4 acceptances; in-flight products are dropped.
    do_start(8'd4, 24'd28, 1'b0);
    issue_ops("mid", 2, 2, 3, 1, 32'h3, 2, -1);
    check_val("mid_busy", busy, 1);
    reset = 1'b0;
    sb_q.delete();
    tick();
    check_val("mid_rst_acc", acc_out, 0);
    check_val("mid_rst_ovf", ovf, 0);
    check_val("mid_rst_valid", out_valid, 0);
    check_val("mid_rst_ready", op_ready, 0);
    check_val("mid_rst_busy", busy, 0);
    reset = 1'b1;
    do_start(8'd1, 24'd5, 1'b0);
    issue_ops("post", 1, 1, 4, 1, 32'h1, 1, -1);
    wait_done("post", cyc);
    check_val("post_latency", cyc, 4);
    release_result("post");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
